// File: rtl/dma_channel_arbiter.sv
// Channel request qualification, priority selection and HRQ/HLDA/DACK handshake
// for an NUM_CH-channel DMA controller, feeding the transfer-timing FSM.
module dma_channel_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              dreq_sense_low,
  input  logic              dack_sense_high,
  input  logic              rot_pri,
  input  logic [NUM_CH-1:0] mask,
  input  logic [NUM_CH-1:0] sw_req,
  input  logic              HLDA,
  input  logic              xfer_done,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [CH_W-1:0]   ch_sel,
  output logic              grant_valid,
  output logic [NUM_CH-1:0] sw_req_clr
);

  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_REQ   = 3'b010;
  localparam logic [2:0] S_GRANT = 3'b100;

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] req_sync, elig;

  logic [2:0]        state_q, state_d;
  logic              hrq_q, hrq_d;
  logic [NUM_CH-1:0] dack_q, dack_d;
  logic              gv_q, gv_d;
  logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
  logic [NUM_CH-1:0] clr_q, clr_d;
  logic [CH_W-1:0]   top_q, top_d;

  logic [CH_W-1:0]   top_eff, win, ch_next;
  logic              found;
  int unsigned       idx;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= DREQ;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign req_sync = sync_q[SYNC_STAGES-1] ^ {NUM_CH{dreq_sense_low}};
  assign elig     = (req_sync & ~mask) | sw_req;

  // Circular search starting at top; fixed mode always starts at channel 0.
  always_comb begin
    top_eff = rot_pri ? top_q : '0;
    win     = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (32'(top_eff) + k) % NUM_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end
  end

  assign ch_next = (ch_sel_q == CH_W'(NUM_CH - 1)) ? '0 : ch_sel_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    hrq_d    = hrq_q;
    dack_d   = dack_q;
    gv_d     = gv_q;
    ch_sel_d = ch_sel_q;
    clr_d    = '0;
    top_d    = rot_pri ? top_q : '0;
    case (state_q)
      S_IDLE: begin
        if (|elig) begin
          ch_sel_d = win;
          hrq_d    = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (HLDA) begin
          state_d          = S_GRANT;
          dack_d           = '0;
          dack_d[ch_sel_q] = 1'b1;
          gv_d             = 1'b1;
        end else if (!elig[ch_sel_q]) begin
          state_d = S_IDLE;
          hrq_d   = 1'b0;
        end
      end
      S_GRANT: begin
        // Losing HLDA ends the grant without crediting the channel as serviced.
        if (!HLDA || xfer_done) begin
          state_d = S_IDLE;
          hrq_d   = 1'b0;
          dack_d  = '0;
          gv_d    = 1'b0;
          if (HLDA) begin
            if (rot_pri) top_d = ch_next;
            clr_d[ch_sel_q] = sw_req[ch_sel_q];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        hrq_d   = 1'b0;
        dack_d  = '0;
        gv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      hrq_q    <= 1'b0;
      dack_q   <= '0;
      gv_q     <= 1'b0;
      ch_sel_q <= '0;
      clr_q    <= '0;
      top_q    <= '0;
    end else begin
      state_q  <= state_d;
      hrq_q    <= hrq_d;
      dack_q   <= dack_d;
      gv_q     <= gv_d;
      ch_sel_q <= ch_sel_d;
      clr_q    <= clr_d;
      top_q    <= top_d;
    end
  end

  assign HRQ         = hrq_q;
  assign DACK        = dack_sense_high ? dack_q : ~dack_q;
  assign ch_sel      = ch_sel_q;
  assign grant_valid = gv_q;
  assign sw_req_clr  = clr_q;

endmodule
